// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change source, the dispenser and the coin mechanism.
// The dispenser takes the slave side; whoever supplies change and coin_ready takes the master side.
interface change_dispenser_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] change_in;
    logic             load;
    logic             coin_ready;
    logic             eject_dollar;
    logic             eject_quarter;
    logic             eject_dime;
    logic             eject_nickel;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] remaining;
    logic [7:0]       coins_out;

    modport master (
        output change_in, load, coin_ready,
        input  eject_dollar, eject_quarter, eject_dime, eject_nickel,
        input  busy, done, error, remaining, coins_out
    );

    modport slave (
        input  change_in, load, coin_ready,
        output eject_dollar, eject_quarter, eject_dime, eject_nickel,
        output busy, done, error, remaining, coins_out
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out a cent amount one coin at a time (100/25/10/5),
// pacing solenoid pulses against the coin mechanism's ready line.
module change_dispenser #(
    parameter int WIDTH        = 16,
    parameter int EJECT_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_READY,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        COIN_DOLLAR,
        COIN_QUARTER,
        COIN_DIME,
        COIN_NICKEL
    } coin_t;

    localparam logic [15:0] EJECT_LAST = 16'(EJECT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_t           state;
    coin_t            coin;
    logic [15:0]      phase;
    logic [WIDTH-1:0] remaining;
    logic [7:0]       coins;
    logic [3:0]       eject;
    logic             busy;
    logic             done;
    logic             error;

    coin_t            pick;
    logic             pick_valid;

    function automatic logic [WIDTH-1:0] coin_value(input coin_t c);
        case (c)
            COIN_DOLLAR:  coin_value = WIDTH'(100);
            COIN_QUARTER: coin_value = WIDTH'(25);
            COIN_DIME:    coin_value = WIDTH'(10);
            default:      coin_value = WIDTH'(5);
        endcase
    endfunction

    // Bit order matches {dollar, quarter, dime, nickel}.
    function automatic logic [3:0] coin_line(input coin_t c);
        case (c)
            COIN_DOLLAR:  coin_line = 4'b1000;
            COIN_QUARTER: coin_line = 4'b0100;
            COIN_DIME:    coin_line = 4'b0010;
            default:      coin_line = 4'b0001;
        endcase
    endfunction

    always_comb begin
        pick       = COIN_NICKEL;
        pick_valid = 1'b1;
        if (remaining >= WIDTH'(100)) begin
            pick = COIN_DOLLAR;
        end else if (remaining >= WIDTH'(25)) begin
            pick = COIN_QUARTER;
        end else if (remaining >= WIDTH'(10)) begin
            pick = COIN_DIME;
        end else if (remaining >= WIDTH'(5)) begin
            pick = COIN_NICKEL;
        end else begin
            pick_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            coin      <= COIN_DOLLAR;
            phase     <= '0;
            remaining <= '0;
            coins     <= '0;
            eject     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (bus.load) begin
                        remaining <= bus.change_in;
                        coins     <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SELECT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_SELECT: begin
                    if (!pick_valid) begin
                        // Any sub-nickel residue stays in remaining and is flagged.
                        error <= (remaining != '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        coin <= pick;
                        if (bus.coin_ready) begin
                            eject <= coin_line(pick);
                            phase <= EJECT_LAST;
                            state <= S_EJECT;
                        end else begin
                            state <= S_WAIT_READY;
                        end
                    end
                end

                S_WAIT_READY: begin
                    if (bus.coin_ready) begin
                        eject <= coin_line(coin);
                        phase <= EJECT_LAST;
                        state <= S_EJECT;
                    end
                end

                S_EJECT: begin
                    if (phase == '0) begin
                        eject     <= '0;
                        remaining <= remaining - coin_value(coin);
                        if (coins != '1) begin
                            coins <= coins + 8'd1;
                        end
                        phase <= GAP_LAST;
                        state <= S_GAP;
                    end else begin
                        phase <= phase - 16'd1;
                    end
                end

                S_GAP: begin
                    if (phase == '0) begin
                        state <= S_SELECT;
                    end else begin
                        phase <= phase - 16'd1;
                    end
                end

                default: begin
                    eject <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.eject_dollar  = eject[3];
    assign bus.eject_quarter = eject[2];
    assign bus.eject_dime    = eject[1];
    assign bus.eject_nickel  = eject[0];
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.error         = error;
    assign bus.remaining     = remaining;
    assign bus.coins_out     = coins;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized ready stalls,
// checked against a division-based greedy change model.
module tb_change_dispenser;

    localparam int WIDTH    = 16;
    localparam int EJECT    = 2;
    localparam int GAP      = 1;
    localparam int COIN_CYC = 1 + EJECT + GAP;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if #(.WIDTH(WIDTH)) bus ();

    change_dispenser #(
        .WIDTH(WIDTH),
        .EJECT_CYCLES(EJECT),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulse history, sampled on the falling edge.
    int unsigned rise_cyc[$];
    int unsigned rise_val[$];
    int unsigned widths[$];
    int unsigned done_cyc[$];
    int overlap = 0;
    int ready_viol = 0;
    int done_long = 0;
    logic [3:0] prev_ej = '0;
    logic prev_ready = 1'b0;
    logic prev_done = 1'b0;
    int run = 0;

    int unsigned exp_coins[$];
    int unsigned exp_residue;

    function automatic int unsigned line_value(input logic [3:0] e);
        case (e)
            4'b1000: line_value = 100;
            4'b0100: line_value = 25;
            4'b0010: line_value = 10;
            4'b0001: line_value = 5;
            default: line_value = 0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [3:0] cur;
        cur = {bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel};
        if ($countones(cur) > 1) overlap++;
        if (cur != 4'b0 && prev_ej != 4'b0 && cur != prev_ej) overlap++;
        if (cur != 4'b0 && prev_ej == 4'b0) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back(line_value(cur));
            if (!prev_ready) ready_viol++;
            run = 1;
        end else if (cur != 4'b0) begin
            run++;
        end
        if (cur == 4'b0 && prev_ej != 4'b0) widths.push_back(run);
        if (bus.done && !prev_done) done_cyc.push_back(cyc);
        if (bus.done && prev_done) done_long++;
        prev_ej    = cur;
        prev_ready = bus.coin_ready;
        prev_done  = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        rise_cyc.delete();
        rise_val.delete();
        widths.delete();
        done_cyc.delete();
        overlap    = 0;
        ready_viol = 0;
        done_long  = 0;
    endtask

    // Greedy breakdown by successive division, independent of any sequencing.
    task automatic build_expected(input int unsigned ch);
        int unsigned r;
        int unsigned nd, nq, ndi, nn;
        exp_coins.delete();
        nd  = ch / 100;  r = ch % 100;
        nq  = r / 25;    r = r % 25;
        ndi = r / 10;    r = r % 10;
        nn  = r / 5;     r = r % 5;
        repeat (nd)  exp_coins.push_back(100);
        repeat (nq)  exp_coins.push_back(25);
        repeat (ndi) exp_coins.push_back(10);
        repeat (nn)  exp_coins.push_back(5);
        exp_residue = r;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.load = 1'b1;
        bus.change_in = 16'd50;
        bus.coin_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel} !== 4'b0) begin
            errors++; $display("FAIL reset_eject: got %b expected 0000",
                {bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel});
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error); end
        checks++;
        if (bus.remaining !== 16'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", bus.remaining); end
        checks++;
        if (bus.coins_out !== 8'd0) begin errors++; $display("FAIL reset_coins: got %0d expected 0", bus.coins_out); end
        bus.load = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dispense(input int unsigned ch);
        int unsigned e0, n, bound, bad_val, bad_cyc, bad_w, exp_co;
        bit timeout;
        build_expected(ch);
        n = exp_coins.size();
        exp_co = (n > 255) ? 255 : n;
        clear_monitor();
        bus.coin_ready = 1'b1;
        bus.change_in = WIDTH'(ch);
        bus.load = 1'b1;
        e0 = cyc + 1;
        tick();
        bus.load = 1'b0;
        bound = 20 + COIN_CYC * (n + 1);
        timeout = 1'b1;
        for (int unsigned i = 0; i < bound; i++) begin
            if (done_cyc.size() != 0) begin timeout = 1'b0; break; end
            tick();
        end
        checks++;
        if (timeout) begin errors++; $display("FAIL disp_timeout ch=%0d: got no done expected done", ch); end
        tick();
        tick();
        checks++;
        if (rise_cyc.size() !== n) begin
            errors++; $display("FAIL disp_count ch=%0d: got %0d pulses expected %0d", ch, rise_cyc.size(), n);
        end
        bad_val = 0; bad_cyc = 0; bad_w = 0;
        for (int unsigned i = 0; i < n && i < rise_val.size(); i++) begin
            if (rise_val[i] != exp_coins[i]) bad_val++;
            if (rise_cyc[i] != e0 + 1 + COIN_CYC * i) bad_cyc++;
        end
        foreach (widths[i]) if (widths[i] != EJECT) bad_w++;
        checks++;
        if (bad_val !== 0) begin errors++; $display("FAIL disp_coin_seq ch=%0d: got %0d wrong coins expected 0", ch, bad_val); end
        checks++;
        if (bad_cyc !== 0) begin errors++; $display("FAIL disp_pulse_time ch=%0d: got %0d mistimed expected 0", ch, bad_cyc); end
        checks++;
        if (bad_w !== 0 || widths.size() !== n) begin
            errors++; $display("FAIL disp_width ch=%0d: got %0d bad of %0d expected 0 bad of %0d", ch, bad_w, widths.size(), n);
        end
        checks++;
        if (done_cyc.size() !== 1) begin
            errors++; $display("FAIL disp_done_count ch=%0d: got %0d expected 1", ch, done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] !== e0 + 1 + COIN_CYC * n) begin
                errors++; $display("FAIL disp_done_time ch=%0d: got %0d expected %0d", ch, done_cyc[0] - e0, 1 + COIN_CYC * n);
            end
        end
        checks++;
        if (bus.remaining !== WIDTH'(exp_residue)) begin
            errors++; $display("FAIL disp_remaining ch=%0d: got %0d expected %0d", ch, bus.remaining, exp_residue);
        end
        checks++;
        if (bus.coins_out !== 8'(exp_co)) begin
            errors++; $display("FAIL disp_coins_out ch=%0d: got %0d expected %0d", ch, bus.coins_out, exp_co);
        end
        checks++;
        if (bus.error !== (exp_residue != 0)) begin
            errors++; $display("FAIL disp_error ch=%0d: got %b expected %b", ch, bus.error, exp_residue != 0);
        end
        checks++;
        if (overlap !== 0 || done_long !== 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL disp_hygiene ch=%0d: got overlap=%0d done_long=%0d busy=%b expected 0 0 0",
                ch, overlap, done_long, bus.busy);
        end
    endtask

    task automatic test_error_hold();
        test_dispense(7);
        repeat (5) tick();
        checks++;
        if (bus.error !== 1'b1) begin errors++; $display("FAIL hold_error: got %b expected 1", bus.error); end
        checks++;
        if (bus.remaining !== 16'd2) begin errors++; $display("FAIL hold_remaining: got %0d expected 2", bus.remaining); end
        test_dispense(25);
    endtask

    task automatic test_wait_ready();
        int unsigned rdy;
        bit timeout;
        clear_monitor();
        bus.coin_ready = 1'b0;
        bus.change_in = 16'd100;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.load = (i == 1);
            if (i == 1) bus.change_in = 16'd55;
            tick();
        end
        bus.load = 1'b0;
        checks++;
        if (rise_cyc.size() !== 0) begin errors++; $display("FAIL stall_eject: got %0d pulses expected 0", rise_cyc.size()); end
        checks++;
        if (bus.remaining !== 16'd100 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL stall_state: got remaining=%0d busy=%b expected 100 1", bus.remaining, bus.busy);
        end
        bus.coin_ready = 1'b1;
        rdy = cyc + 1;
        timeout = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done_cyc.size() != 0) begin timeout = 1'b0; break; end
            tick();
        end
        tick();
        checks++;
        if (timeout) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++;
        if (rise_cyc.size() !== 1) begin
            errors++; $display("FAIL stall_pulses: got %0d expected 1", rise_cyc.size());
        end else begin
            checks++;
            if (rise_cyc[0] !== rdy || rise_val[0] !== 100) begin
                errors++; $display("FAIL stall_rise: got cyc+%0d value %0d expected cyc+0 value 100", rise_cyc[0] - rdy, rise_val[0]);
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || (done_cyc.size() == 1 && done_cyc[0] !== rdy + EJECT + GAP + 1)) begin
            errors++; $display("FAIL stall_done: got %0d done pulses expected 1 at ready+%0d", done_cyc.size(), EJECT + GAP + 1);
        end
        checks++;
        if (bus.remaining !== 16'd0 || bus.coins_out !== 8'd1) begin
            errors++; $display("FAIL stall_final: got remaining=%0d coins=%0d expected 0 1", bus.remaining, bus.coins_out);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned e0;
        clear_monitor();
        bus.coin_ready = 1'b1;
        bus.change_in = 16'd10;
        bus.load = 1'b1;
        e0 = cyc + 1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            tick();
        end
        bus.change_in = 16'd5;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_cyc.size() >= 2) break;
            tick();
        end
        tick();
        checks++;
        if (done_cyc.size() !== 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] !== e0 + 5 || done_cyc[1] !== e0 + 11) begin
                errors++; $display("FAIL b2b_done_time: got +%0d/+%0d expected +5/+11", done_cyc[0] - e0, done_cyc[1] - e0);
            end
        end
        checks++;
        if (rise_val.size() !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d expected 2", rise_val.size());
        end else begin
            checks++;
            if (rise_val[0] !== 10 || rise_val[1] !== 5 || rise_cyc[1] !== e0 + 7) begin
                errors++; $display("FAIL b2b_seq: got %0d,%0d at +%0d expected 10,5 at +7", rise_val[0], rise_val[1], rise_cyc[1] - e0);
            end
        end
        checks++;
        if (bus.coins_out !== 8'd1 || bus.remaining !== 16'd0 || done_long !== 0) begin
            errors++; $display("FAIL b2b_final: got coins=%0d remaining=%0d done_long=%0d expected 1 0 0",
                bus.coins_out, bus.remaining, done_long);
        end
    endtask

    task automatic test_reset_mid();
        clear_monitor();
        bus.coin_ready = 1'b1;
        bus.change_in = 16'd175;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (9) tick();
        checks++;
        if (bus.eject_quarter !== 1'b1 || bus.coins_out !== 8'd2) begin
            errors++; $display("FAIL mid_precondition: got quarter=%b coins=%0d expected 1 2", bus.eject_quarter, bus.coins_out);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel, bus.busy, bus.done} !== 6'b0) begin
            errors++; $display("FAIL mid_cut: got ejects/busy/done=%b expected 000000",
                {bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel, bus.busy, bus.done});
        end
        checks++;
        if (bus.remaining !== 16'd0 || bus.coins_out !== 8'd0) begin
            errors++; $display("FAIL mid_clear: got remaining=%0d coins=%0d expected 0 0", bus.remaining, bus.coins_out);
        end
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if (done_cyc.size() !== 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cyc.size()); end
        test_dispense(100);
    endtask

    task automatic test_random();
        int unsigned ch, bad;
        bit timeout;
        for (int it = 0; it < 8; it++) begin
            ch = $urandom_range(0, 600);
            build_expected(ch);
            clear_monitor();
            bus.coin_ready = 1'b1;
            bus.change_in = WIDTH'(ch);
            bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            timeout = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if (done_cyc.size() != 0) begin timeout = 1'b0; break; end
                bus.coin_ready = ($urandom_range(0, 3) != 0);
                if (bus.busy && $urandom_range(0, 7) == 0) begin
                    bus.load = 1'b1;
                    bus.change_in = 16'($urandom);
                end else begin
                    bus.load = 1'b0;
                end
                tick();
            end
            bus.load = 1'b0;
            bus.coin_ready = 1'b1;
            tick();
            bad = 0;
            for (int unsigned i = 0; i < exp_coins.size() && i < rise_val.size(); i++)
                if (rise_val[i] != exp_coins[i]) bad++;
            foreach (widths[i]) if (widths[i] != EJECT) bad++;
            checks++;
            if (timeout || rise_val.size() !== exp_coins.size() || bad !== 0) begin
                errors++; $display("FAIL rand_seq ch=%0d: got %0d pulses %0d bad timeout=%b expected %0d pulses 0 bad",
                    ch, rise_val.size(), bad, timeout, exp_coins.size());
            end
            checks++;
            if (ready_viol !== 0 || overlap !== 0 || done_cyc.size() !== 1) begin
                errors++; $display("FAIL rand_handshake ch=%0d: got ready_viol=%0d overlap=%0d dones=%0d expected 0 0 1",
                    ch, ready_viol, overlap, done_cyc.size());
            end
            checks++;
            if (bus.remaining !== WIDTH'(exp_residue) || bus.error !== (exp_residue != 0) ||
                bus.coins_out !== 8'(exp_coins.size())) begin
                errors++; $display("FAIL rand_final ch=%0d: got rem=%0d err=%b coins=%0d expected %0d %b %0d",
                    ch, bus.remaining, bus.error, bus.coins_out, exp_residue, exp_residue != 0, exp_coins.size());
            end
            tick();
        end
    endtask

    initial begin
        bus.change_in  = '0;
        bus.load       = 1'b0;
        bus.coin_ready = 1'b0;
        test_reset();
        test_dispense(50);
        test_dispense(190);
        test_dispense(0);
        test_dispense(2);
        test_error_hold();
        test_wait_ready();
        test_back_to_back();
        test_reset_mid();
        test_dispense(65535);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
